// File: rtl/rtmc_pkg.sv
// Shared types for the RTMC SPI front end: command byte layout and
// the frame-level state encoding.
package rtmc_pkg;

    localparam logic SPI_RW_READ = 1'b1;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
    } spi_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA
    } spi_state_t;

endpackage

// File: rtl/rtmc_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pad signal, with single-cycle
// rise/fall pulses taken from the synchronized level.
module rtmc_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Resetting to 0 means a line already low at reset release never
    // produces a fall pulse; it must go high and low again first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/rtmc_spi_target.sv
// SPI mode-0 target: decodes a command byte plus burst data bytes into
// single-cycle register strobes with auto-incrementing address.
module rtmc_spi_target
    import rtmc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sclk,
    input  logic              i_cs,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic [ADDR_W-1:0] o_reg_addr,
    output logic [DATA_W-1:0] o_reg_wdata,
    output logic              o_reg_we,
    output logic              o_reg_re,
    input  logic [DATA_W-1:0] i_reg_rdata,
    output logic              o_frame_active,
    output logic              o_frame_err
);
    localparam int CNT_W = $clog2(DATA_W);

    spi_state_t             r_state;
    spi_state_t             w_state_next;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   w_mosi_s;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic                   w_in_frame;
    logic                   w_shift;
    logic                   w_fall;
    logic                   w_byte_done;
    logic [CNT_W-1:0]       r_bitcnt;
    logic [DATA_W-1:0]      r_rx;
    logic [DATA_W-1:0]      r_tx;
    logic [DATA_W-1:0]      r_hold;
    logic [DATA_W-1:0]      w_rx_next;
    logic                   r_boundary;
    logic [ADDR_W-1:0]      r_reg_addr;
    logic [DATA_W-1:0]      r_reg_wdata;
    logic                   r_we;
    logic                   r_re;
    logic                   r_re_d;
    logic                   r_addr_inc;
    logic                   r_frame_err;
    spi_cmd_t               w_cmd;

    rtmc_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_sclk),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    rtmc_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_cs),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // mosi gets the same depth as sclk so a sampled bit lines up with its edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_mosi_sync <= '0;
        else          r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
    end

    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_in_frame  = (r_state != IDLE);
    assign w_shift     = w_sclk_rise & w_in_frame & ~w_cs_rise;
    assign w_fall      = w_sclk_fall & w_in_frame & ~w_cs_rise;
    assign w_byte_done = w_shift & (r_bitcnt == '1);
    assign w_rx_next   = {r_rx[DATA_W-2:0], w_mosi_s};
    assign w_cmd       = spi_cmd_t'(w_rx_next[7:0]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_cs_rise) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_cs_fall) w_state_next = CMD;
                CMD:     if (w_byte_done)
                             w_state_next = (w_cmd.rw == SPI_RW_READ) ? RDATA : WDATA;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        o_frame_active = w_in_frame;
        o_miso         = w_in_frame & r_tx[DATA_W-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bitcnt    <= '0;
            r_rx        <= '0;
            r_tx        <= '0;
            r_hold      <= '0;
            r_boundary  <= 1'b0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_re_d      <= 1'b0;
            r_addr_inc  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_addr_inc  <= 1'b0;
            r_frame_err <= 1'b0;
            r_re_d      <= r_re;
            if (r_re_d)     r_hold     <= i_reg_rdata;
            if (r_addr_inc) r_reg_addr <= r_reg_addr + ADDR_W'(1);

            if (w_cs_rise) begin
                r_bitcnt    <= '0;
                r_boundary  <= 1'b0;
                r_frame_err <= (r_bitcnt != '0);
            end else if (!w_in_frame) begin
                if (w_cs_fall) begin
                    r_bitcnt   <= '0;
                    r_rx       <= '0;
                    r_tx       <= '0;
                    r_hold     <= '0;
                    r_boundary <= 1'b0;
                end
            end else begin
                if (w_shift) begin
                    r_rx     <= w_rx_next;
                    r_bitcnt <= r_bitcnt + CNT_W'(1);
                end
                if (w_byte_done) begin
                    r_boundary <= 1'b1;
                    case (r_state)
                        CMD: begin
                            r_reg_addr <= ADDR_W'(w_cmd.addr);
                            r_re       <= (w_cmd.rw == SPI_RW_READ);
                        end
                        WDATA: begin
                            r_reg_wdata <= w_rx_next;
                            r_we        <= 1'b1;
                            r_addr_inc  <= 1'b1;
                        end
                        RDATA: begin
                            r_reg_addr <= r_reg_addr + ADDR_W'(1);
                            r_re       <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Loading on the first fall after a completed byte keeps the
                // fresh MSB on miso instead of shifting it away immediately.
                if (w_fall) begin
                    if (r_boundary) begin
                        r_tx       <= r_hold;
                        r_boundary <= 1'b0;
                    end else begin
                        r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_we    = r_we;
    assign o_reg_re    = r_re;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_rtmc_spi_target.sv
// Self-checking bench for rtmc_spi_target: table-driven bursts, hand-written
// abort/reset/idle sequences, then random bursts against a reference model.
module tb_rtmc_spi_target;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       cs = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata = 8'h00;
   logic       frame_active;
   logic       frame_err;

   int vectors = 0;
   int miscompares = 0;

   logic [14:0] weQ[$];
   logic [6:0]  reQ[$];
   int          errCount = 0;
   int          bothCount = 0;
   int          idleMisoCount = 0;
   logic [7:0]  regSalt = 8'h00;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [3:0]  nb;
      logic [23:0] din;
      logic [3:0]  expN;
      logic [20:0] expAddr;
      logic [23:0] expData;
      logic [23:0] expMiso;
   } vec_t;

   localparam int NVEC = 6;
   vec_t tbl[NVEC];

   rtmc_spi_target dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_sclk         (sclk),
      .i_cs           (cs),
      .i_mosi         (mosi),
      .o_miso         (miso),
      .o_reg_addr     (reg_addr),
      .o_reg_wdata    (reg_wdata),
      .o_reg_we       (reg_we),
      .o_reg_re       (reg_re),
      .i_reg_rdata    (reg_rdata),
      .o_frame_active (frame_active),
      .o_frame_err    (frame_err)
   );

   // System clock.
   always #5 clk = ~clk;

   // Register file contents as seen by reads: address-derived, optionally salted.
   function automatic logic [7:0] regValue(input logic [6:0] a);
      return {1'b0, a} ^ 8'hFF ^ regSalt;
   endfunction

   // Register file read port: data valid only in the cycle after reg_re.
   always @(posedge clk) begin
      if (reg_re) reg_rdata <= regValue(reg_addr);
      else        reg_rdata <= 8'($urandom);
   end

   // Strobe and invariant monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (reg_we) weQ.push_back({reg_addr, reg_wdata});
      if (reg_re) reQ.push_back(reg_addr);
      if (frame_err) errCount <= errCount + 1;
      if (reg_we && reg_re) bothCount <= bothCount + 1;
      if (!frame_active && miso) idleMisoCount <= idleMisoCount + 1;
   end

   // Overall time limit so a broken design cannot stall the run.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "[TB] time limit");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic waitClks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SPI mode-0 byte (or leading part of one), MSB first, sclk = clk/8.
   task automatic spiXfer(input logic [7:0] txByte, input int nbits, output logic [7:0] rxByte);
      rxByte = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = txByte[i];
         waitClks(4);
         rxByte[i] = miso;
         sclk = 1'b1;
         waitClks(4);
         sclk = 1'b0;
      end
   endtask

   // Complete frame: command byte plus nb data bytes taken MSB-first from din.
   task automatic applyStimulus(input logic [7:0] cmd, input int nb, input logic [31:0] din,
                                output logic [31:0] misoBytes);
      logic [7:0] rx;
      misoBytes = '0;
      cs = 1'b0;
      waitClks(8);
      spiXfer(cmd, 8, rx);
      misoBytes[31:24] = rx;
      for (int k = 0; k < nb; k++) begin
         spiXfer(din[31-8*k -: 8], 8, rx);
         misoBytes[31-8*(k+1) -: 8] = rx;
      end
      waitClks(4);
      cs = 1'b1;
      waitClks(24);
   endtask

   // Reference model: a write burst writes consecutive (wrapping) addresses;
   // a read burst reads the command address plus one prefetch per data byte,
   // and miso carries zero during the command then each read value in turn.
   task automatic checkBurst(input logic [7:0] cmd, input int nb, input logic [31:0] din,
                             input logic [31:0] misoBytes, input int we0, input int re0, input int err0);
      logic [6:0]  a;
      logic [14:0] expWe[$];
      logic [6:0]  expRe[$];
      logic [7:0]  expMiso[$];
      a = cmd[6:0];
      expMiso.push_back(8'h00);
      if (cmd[7]) begin
         for (int k = 0; k <= nb; k++) expRe.push_back(7'(a + k));
         for (int k = 1; k <= nb; k++) expMiso.push_back(regValue(7'(a + k - 1)));
      end else begin
         for (int k = 0; k < nb; k++) begin
            expWe.push_back({7'(a + k), din[31-8*k -: 8]});
            expMiso.push_back(8'h00);
         end
      end
      checkOutput("rand we count", 32'(weQ.size() - we0), 32'(expWe.size()));
      for (int k = 0; k < expWe.size() && we0 + k < weQ.size(); k++)
         checkOutput("rand we addr/data", 32'(weQ[we0+k]), 32'(expWe[k]));
      checkOutput("rand re count", 32'(reQ.size() - re0), 32'(expRe.size()));
      for (int k = 0; k < expRe.size() && re0 + k < reQ.size(); k++)
         checkOutput("rand re addr", 32'(reQ[re0+k]), 32'(expRe[k]));
      for (int k = 0; k < expMiso.size(); k++)
         checkOutput("rand miso byte", 32'(misoBytes[31-8*k -: 8]), 32'(expMiso[k]));
      checkOutput("rand frame_err", 32'(errCount - err0), 32'd0);
   endtask

   initial begin
      logic [31:0] misoBytes;
      logic [7:0]  rx;
      int          we0, re0, err0, nStrobe, nb;
      logic [7:0]  cmd;
      logic [31:0] din;

      tbl[0] = '{cmd: 8'h05, nb: 4'd2, din: 24'hA53C00, expN: 4'd2,
                 expAddr: {7'h05, 7'h06, 7'h00}, expData: 24'hA53C00, expMiso: 24'h000000};
      tbl[1] = '{cmd: 8'h90, nb: 4'd2, din: 24'h000000, expN: 4'd3,
                 expAddr: {7'h10, 7'h11, 7'h12}, expData: 24'h000000, expMiso: 24'h00EFEE};
      tbl[2] = '{cmd: 8'h7F, nb: 4'd2, din: 24'h112200, expN: 4'd2,
                 expAddr: {7'h7F, 7'h00, 7'h00}, expData: 24'h112200, expMiso: 24'h000000};
      tbl[3] = '{cmd: 8'h85, nb: 4'd1, din: 24'h000000, expN: 4'd2,
                 expAddr: {7'h05, 7'h06, 7'h00}, expData: 24'h000000, expMiso: 24'h00FA00};
      tbl[4] = '{cmd: 8'hFF, nb: 4'd1, din: 24'h000000, expN: 4'd2,
                 expAddr: {7'h7F, 7'h00, 7'h00}, expData: 24'h000000, expMiso: 24'h008000};
      tbl[5] = '{cmd: 8'h00, nb: 4'd1, din: 24'h5A0000, expN: 4'd1,
                 expAddr: {7'h00, 7'h00, 7'h00}, expData: 24'h5A0000, expMiso: 24'h000000};

      // Reset with cs already low: outputs idle, no frame until cs goes high then low.
      cs = 1'b0;
      waitClks(5);
      checkOutput("reset frame_active", 32'(frame_active), 32'd0);
      checkOutput("reset miso", 32'(miso), 32'd0);
      checkOutput("reset reg_we", 32'(reg_we), 32'd0);
      checkOutput("reset reg_re", 32'(reg_re), 32'd0);
      checkOutput("reset reg_addr", 32'(reg_addr), 32'd0);
      checkOutput("reset reg_wdata", 32'(reg_wdata), 32'd0);
      checkOutput("reset frame_err", 32'(frame_err), 32'd0);
      rst_n = 1'b1;
      waitClks(6);
      spiXfer(8'h85, 8, rx);
      spiXfer(8'h3C, 8, rx);
      waitClks(8);
      checkOutput("cs-low-at-reset frame_active", 32'(frame_active), 32'd0);
      checkOutput("cs-low-at-reset strobes", 32'(weQ.size() + reQ.size()), 32'd0);
      cs = 1'b1;
      waitClks(10);

      // Table-driven bursts with hand-computed expectations.
      for (int v = 0; v < NVEC; v++) begin
         we0  = weQ.size();
         re0  = reQ.size();
         err0 = errCount;
         applyStimulus(tbl[v].cmd, int'(tbl[v].nb), {tbl[v].din, 8'h00}, misoBytes);
         nStrobe = tbl[v].cmd[7] ? reQ.size() - re0 : weQ.size() - we0;
         checkOutput($sformatf("vec%0d strobe count", v), 32'(nStrobe), 32'(tbl[v].expN));
         checkOutput($sformatf("vec%0d other strobe count", v),
                     32'(tbl[v].cmd[7] ? weQ.size() - we0 : reQ.size() - re0), 32'd0);
         for (int k = 0; k < int'(tbl[v].expN) && k < nStrobe; k++) begin
            if (tbl[v].cmd[7])
               checkOutput($sformatf("vec%0d re addr %0d", v, k), 32'(reQ[re0+k]),
                           32'(tbl[v].expAddr[20-7*k -: 7]));
            else
               checkOutput($sformatf("vec%0d we addr/data %0d", v, k), 32'(weQ[we0+k]),
                           32'({tbl[v].expAddr[20-7*k -: 7], tbl[v].expData[23-8*k -: 8]}));
         end
         for (int k = 0; k <= int'(tbl[v].nb); k++)
            checkOutput($sformatf("vec%0d miso byte %0d", v, k), 32'(misoBytes[31-8*k -: 8]),
                        32'(tbl[v].expMiso[23-8*k -: 8]));
         checkOutput($sformatf("vec%0d frame_err", v), 32'(errCount - err0), 32'd0);
      end

      // Abort after 5 bits of the first data byte, then a normal frame.
      we0  = weQ.size();
      re0  = reQ.size();
      err0 = errCount;
      cs = 1'b0;
      waitClks(8);
      spiXfer(8'h02, 8, rx);
      spiXfer(8'hFF, 5, rx);
      waitClks(4);
      cs = 1'b1;
      waitClks(24);
      checkOutput("abort we count", 32'(weQ.size() - we0), 32'd0);
      checkOutput("abort re count", 32'(reQ.size() - re0), 32'd0);
      checkOutput("abort frame_err pulses", 32'(errCount - err0), 32'd1);
      checkOutput("abort frame_active", 32'(frame_active), 32'd0);
      applyStimulus(8'h02, 1, 32'h77000000, misoBytes);
      checkOutput("post-abort we count", 32'(weQ.size() - we0), 32'd1);
      if (weQ.size() > we0)
         checkOutput("post-abort we addr/data", 32'(weQ[we0]), 32'({7'h02, 8'h77}));
      checkOutput("post-abort frame_err pulses", 32'(errCount - err0), 32'd1);

      // Reset during the 3rd data bit with cs held low.
      cs = 1'b0;
      waitClks(8);
      spiXfer(8'h03, 8, rx);
      spiXfer(8'hAA, 2, rx);
      mosi = 1'b1;
      waitClks(2);
      rst_n = 1'b0;
      waitClks(2);
      checkOutput("midreset frame_active", 32'(frame_active), 32'd0);
      checkOutput("midreset miso", 32'(miso), 32'd0);
      checkOutput("midreset reg_addr", 32'(reg_addr), 32'd0);
      checkOutput("midreset strobes", 32'({reg_we, reg_re}), 32'd0);
      rst_n = 1'b1;
      we0  = weQ.size();
      re0  = reQ.size();
      err0 = errCount;
      waitClks(2);
      sclk = 1'b1;
      waitClks(4);
      sclk = 1'b0;
      spiXfer(8'h55, 5, rx);
      spiXfer(8'h81, 8, rx);
      waitClks(4);
      checkOutput("post-reset cs-low frame_active", 32'(frame_active), 32'd0);
      cs = 1'b1;
      waitClks(24);
      checkOutput("post-reset strobes", 32'((weQ.size() - we0) + (reQ.size() - re0)), 32'd0);
      checkOutput("post-reset frame_err", 32'(errCount - err0), 32'd0);
      applyStimulus(8'h01, 1, 32'h55000000, misoBytes);
      checkOutput("post-reset write count", 32'(weQ.size() - we0), 32'd1);
      if (weQ.size() > we0)
         checkOutput("post-reset we addr/data", 32'(weQ[we0]), 32'({7'h01, 8'h55}));

      // sclk activity while cs is high must be ignored.
      we0 = weQ.size();
      re0 = reQ.size();
      for (int i = 0; i < 16; i++) begin
         mosi = 1'($urandom);
         waitClks(4);
         sclk = 1'b1;
         waitClks(4);
         sclk = 1'b0;
         if (i == 9) checkOutput("idle miso", 32'(miso), 32'd0);
      end
      waitClks(8);
      checkOutput("idle frame_active", 32'(frame_active), 32'd0);
      checkOutput("idle strobes", 32'((weQ.size() - we0) + (reQ.size() - re0)), 32'd0);

      // Random bursts checked against the reference model.
      for (int t = 0; t < 24; t++) begin
         regSalt = 8'($urandom);
         cmd  = 8'($urandom);
         nb   = int'($urandom_range(1, 3));
         din  = $urandom;
         we0  = weQ.size();
         re0  = reQ.size();
         err0 = errCount;
         applyStimulus(cmd, nb, din, misoBytes);
         checkBurst(cmd, nb, din, misoBytes, we0, re0, err0);
      end

      checkOutput("we/re never together", 32'(bothCount), 32'd0);
      checkOutput("miso low outside frames", 32'(idleMisoCount), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
